// File: rtl/dmem_arbiter.sv
// Arbitrates one single-port data memory between the CPU port (fixed priority) and an aux port,
// with bounded aux starvation and aux burst locking. Optional counters under DMARB_STATS_EN.
module dmem_arbiter #(
    parameter int unsigned AW       = 7,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [31:0]   c_rdata,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    input  logic          a_lock,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [31:0]   a_rdata,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_din,
    input  logic [31:0]   m_dout
`ifdef DMARB_STATS_EN
    ,
    output logic [15:0]   stat_conflict,
    output logic [15:0]   stat_forced
`endif
);

    localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        c_win, a_win, forced;
    logic        c_rvalid_q, a_rvalid_q;
    logic [31:0] c_rdata_q, a_rdata_q;

    // Reset also suppresses every grant so nothing reaches memory while it is held.
    always_comb begin
        state_d = state_q;
        c_win   = 1'b0;
        a_win   = 1'b0;
        forced  = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    a_win  = a_req && (!c_req || wait_q == MAX_WAIT_W);
                    c_win  = c_req && !a_win;
                    forced = a_win && c_req;
                    if (a_win && a_lock) state_d = StLocked;
                end
                StLocked: begin
                    a_win = a_req;
                    if (!a_req || !a_lock) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (a_win || !a_req) begin
            wait_d = 8'd0;
        end else if (state_q == StIdle && wait_q != MAX_WAIT_W) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_comb begin
        m_we   = 1'b0;
        m_addr = '0;
        m_din  = '0;
        if (c_win) begin
            m_we   = c_we;
            m_addr = c_addr;
            m_din  = c_wdata;
        end else if (a_win) begin
            m_we   = a_we;
            m_addr = a_addr;
            m_din  = a_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_q     <= 8'd0;
            c_rvalid_q <= 1'b0;
            a_rvalid_q <= 1'b0;
            c_rdata_q  <= 32'd0;
            a_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            c_rvalid_q <= c_win && !c_we;
            a_rvalid_q <= a_win && !a_we;
            if (c_win && !c_we) c_rdata_q <= m_dout;
            if (a_win && !a_we) a_rdata_q <= m_dout;
        end
    end

    assign c_gnt    = c_win;
    assign a_gnt    = a_win;
    assign c_rvalid = c_rvalid_q;
    assign a_rvalid = a_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign a_rdata  = a_rdata_q;

`ifdef DMARB_STATS_EN
    logic [15:0] conflict_q, forced_q;
    logic        conflict;

    assign conflict = c_req && a_req && (c_win || a_win);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= 16'd0;
            forced_q   <= 16'd0;
        end else begin
            if (conflict && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
            if (forced && forced_q != 16'hFFFF) forced_q <= forced_q + 16'd1;
        end
    end

    assign stat_conflict = conflict_q;
    assign stat_forced   = forced_q;
`endif

endmodule
